// File: rtl/bin_bcd_seg_conv.sv
// 8-bit binary to BCD converter (iterative double-dabble, one bit per clock)
// with active-low 7-segment decoders for two hex digits and two decimal digits.
module bin_bcd_seg_conv (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  bin,
  output logic        busy,
  output logic        done,
  output logic [11:0] bcd,
  output logic        overflow,
  output logic [6:0]  hex_lo,
  output logic [6:0]  hex_hi,
  output logic [6:0]  dec_lo,
  output logic [6:0]  dec_hi
);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_e;

  localparam logic [6:0] SEG_ZERO = 7'b1000000;
  localparam logic [6:0] SEG_OVF  = 7'b0011100;

  // Segment order {g,f,e,d,c,b,a}; table holds lit patterns, output is active-low.
  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] lit;
    case (n)
      4'h0: lit = 7'h3F;  4'h1: lit = 7'h06;  4'h2: lit = 7'h5B;  4'h3: lit = 7'h4F;
      4'h4: lit = 7'h66;  4'h5: lit = 7'h6D;  4'h6: lit = 7'h7D;  4'h7: lit = 7'h07;
      4'h8: lit = 7'h7F;  4'h9: lit = 7'h6F;  4'hA: lit = 7'h77;  4'hB: lit = 7'h7C;
      4'hC: lit = 7'h39;  4'hD: lit = 7'h5E;  4'hE: lit = 7'h79;  default: lit = 7'h71;
    endcase
    return ~lit;
  endfunction

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  sreg_q, sreg_d;
  logic [7:0]  bin_q, bin_d;
  logic [11:0] scr_q, scr_d;
  logic [11:0] adj;
  logic        ovf_c;
  logic        done_q, done_d;
  logic [11:0] bcd_q, bcd_d;
  logic        ovf_q, ovf_d;
  logic [6:0]  hex_lo_q, hex_lo_d, hex_hi_q, hex_hi_d;
  logic [6:0]  dec_lo_q, dec_lo_d, dec_hi_q, dec_hi_d;

  always_comb begin
    for (int i = 0; i < 3; i++)
      adj[4*i +: 4] = (scr_q[4*i +: 4] >= 4'd5) ? scr_q[4*i +: 4] + 4'd3 : scr_q[4*i +: 4];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sreg_d   = sreg_q;
    bin_d    = bin_q;
    scr_d    = scr_q;
    done_d   = 1'b0;
    bcd_d    = bcd_q;
    ovf_d    = ovf_q;
    hex_lo_d = hex_lo_q;
    hex_hi_d = hex_hi_q;
    dec_lo_d = dec_lo_q;
    dec_hi_d = dec_hi_q;
    ovf_c    = (bin_q > 8'h63);
    case (state_q)
      IDLE: begin
        if (start) begin
          bin_d   = bin;
          sreg_d  = bin;
          scr_d   = 12'h000;
          cnt_d   = 3'd0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {scr_d, sreg_d} = {adj, sreg_q} << 1;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = COMMIT;
      end
      COMMIT: begin
        // bin_q is kept separately because sreg_q has been shifted out by now.
        bcd_d    = scr_q;
        ovf_d    = ovf_c;
        hex_lo_d = seg7(bin_q[3:0]);
        hex_hi_d = seg7(bin_q[7:4]);
        dec_lo_d = ovf_c ? SEG_OVF : seg7(scr_q[3:0]);
        dec_hi_d = ovf_c ? SEG_OVF : seg7(scr_q[7:4]);
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 3'd0;
      sreg_q   <= 8'h00;
      bin_q    <= 8'h00;
      scr_q    <= 12'h000;
      done_q   <= 1'b0;
      bcd_q    <= 12'h000;
      ovf_q    <= 1'b0;
      hex_lo_q <= SEG_ZERO;
      hex_hi_q <= SEG_ZERO;
      dec_lo_q <= SEG_ZERO;
      dec_hi_q <= SEG_ZERO;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sreg_q   <= sreg_d;
      bin_q    <= bin_d;
      scr_q    <= scr_d;
      done_q   <= done_d;
      bcd_q    <= bcd_d;
      ovf_q    <= ovf_d;
      hex_lo_q <= hex_lo_d;
      hex_hi_q <= hex_hi_d;
      dec_lo_q <= dec_lo_d;
      dec_hi_q <= dec_hi_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign bcd      = bcd_q;
  assign overflow = ovf_q;
  assign hex_lo   = hex_lo_q;
  assign hex_hi   = hex_hi_q;
  assign dec_lo   = dec_lo_q;
  assign dec_hi   = dec_hi_q;

endmodule

// File: tb/tb_bin_bcd_seg_conv.sv
// Bench for bin_bcd_seg_conv: fixed vector table, exhaustive and random sweeps
// against an arithmetic model, plus start-while-busy and mid-conversion reset.
module tb_bin_bcd_seg_conv;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  bin = 8'h00;
  logic        busy, done, overflow;
  logic [11:0] bcd;
  logic [6:0]  hex_lo, hex_hi, dec_lo, dec_hi;

  int n_cmp = 0;
  int n_err = 0;

  bin_bcd_seg_conv dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
    .busy(busy), .done(done), .bcd(bcd), .overflow(overflow),
    .hex_lo(hex_lo), .hex_hi(hex_hi), .dec_lo(dec_lo), .dec_hi(dec_hi)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] ZERO = 7'b1000000;
  localparam logic [6:0] GLYPH = 7'b0011100;

  logic [6:0] lit_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  typedef struct {
    logic [7:0]  v;
    logic [11:0] e_bcd;
    logic        e_ovf;
    logic [6:0]  e_hh, e_hl, e_dh, e_dl;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] segm(input int d);
    return ~lit_tab[d];
  endfunction

  // Run one conversion starting at a negedge; returns at the negedge where done is seen.
  task automatic run(input logic [7:0] v);
    int lat;
    start = 1'b1; bin = v;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; bin = 8'($urandom);
    chk("busy_after_accept", busy, 1);
    chk("done_low_after_accept", done, 0);
    lat = 0;
    while (!done && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, 9);
  endtask

  task automatic check_model(input logic [7:0] v);
    int h, t, o;
    logic ov;
    h = v / 100; t = (v / 10) % 10; o = v % 10;
    ov = (v > 99);
    chk("m_bcd", bcd, (h << 8) | (t << 4) | o);
    chk("m_ovf", overflow, ov);
    chk("m_hex_hi", hex_hi, segm(v / 16));
    chk("m_hex_lo", hex_lo, segm(v % 16));
    chk("m_dec_hi", dec_hi, ov ? GLYPH : segm(t));
    chk("m_dec_lo", dec_lo, ov ? GLYPH : segm(o));
    chk("m_busy_at_done", busy, 0);
  endtask

  task automatic check_reset_vals();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_bcd", bcd, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_hex_lo", hex_lo, ZERO);
    chk("rst_hex_hi", hex_hi, ZERO);
    chk("rst_dec_lo", dec_lo, ZERO);
    chk("rst_dec_hi", dec_hi, ZERO);
  endtask

  initial begin
    int nd, gap;
    logic [7:0] rv;

    vecs[0] = '{8'h2A, 12'h042, 1'b0, 7'b0100100, 7'b0001000, 7'b0011001, 7'b0100100};
    vecs[1] = '{8'h63, 12'h099, 1'b0, 7'b0000010, 7'b0110000, 7'b0010000, 7'b0010000};
    vecs[2] = '{8'h64, 12'h100, 1'b1, 7'b0000010, 7'b0011001, GLYPH, GLYPH};
    vecs[3] = '{8'hFF, 12'h255, 1'b1, 7'b0001110, 7'b0001110, GLYPH, GLYPH};
    vecs[4] = '{8'h00, 12'h000, 1'b0, ZERO, ZERO, ZERO, ZERO};
    vecs[5] = '{8'h09, 12'h009, 1'b0, ZERO, 7'b0010000, ZERO, 7'b0010000};

    #12;
    check_reset_vals();
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run(vecs[i].v);
      chk("v_bcd", bcd, vecs[i].e_bcd);
      chk("v_ovf", overflow, vecs[i].e_ovf);
      chk("v_hex_hi", hex_hi, vecs[i].e_hh);
      chk("v_hex_lo", hex_lo, vecs[i].e_hl);
      chk("v_dec_hi", dec_hi, vecs[i].e_dh);
      chk("v_dec_lo", dec_lo, vecs[i].e_dl);
      @(negedge clk);
      chk("v_done_single", done, 0);
    end

    // Exhaustive sweep, back-to-back (start on the cycle after done).
    for (int v = 0; v < 256; v++) begin
      run(8'(v));
      check_model(8'(v));
    end

    // Random values with random idle gaps.
    for (int k = 0; k < 40; k++) begin
      rv = 8'($urandom);
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) @(negedge clk);
      run(rv);
      check_model(rv);
    end

    // start re-pulsed at cycles 3 and 9 (commit edge) with a different bin.
    @(negedge clk);
    start = 1'b1; bin = 8'h2A;
    @(posedge clk);
    @(negedge clk);
    nd = 0;
    for (int k = 1; k <= 12; k++) begin
      start = (k == 3 || k == 9);
      bin = start ? 8'hFF : 8'($urandom);
      @(negedge clk);
      if (done) begin
        nd++;
        chk("busy_done_cycle", k, 9);
        chk("busy_bcd", bcd, 12'h042);
        chk("busy_dec_hi", dec_hi, 7'b0011001);
      end
    end
    start = 1'b0;
    chk("busy_done_count", nd, 1);
    chk("busy_idle_after", busy, 0);

    // Reset during iteration 4.
    @(negedge clk);
    start = 1'b1; bin = 8'hC8;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    nd = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (done) nd++;
    end
    #2 rst_n = 1'b0;
    #1 check_reset_vals();
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("rst_no_done", nd, 0);
    chk("rst_idle", busy, 0);
    run(8'h7B);
    check_model(8'h7B);
    chk("post_rst_bcd", bcd, 12'h123);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bin_bcd_seg_conv.md
# bin_bcd_seg_conv

Sequential binary-to-BCD converter with four active-low 7-segment digit decoders, for board-level number-system displays. It converts an 8-bit binary value to three BCD digits using an iterative double-dabble (shift-and-add-3) engine, one bit per clock. It then drives two hexadecimal digits (raw nibbles) and two decimal digits (tens/ones), with an overflow glyph when the value exceeds 99. It sits between debounced switch/key logic and the HEX display pins.

## Interface
- No parameters; data width is fixed at 8 bits.
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  conversion request, sampled on the rising edge; ignored while busy.
- bin  input  8  binary value; captured on the edge that accepts start.
- busy  output  1  high while a conversion is in progress.
- done  output  1  single-cycle pulse when results are committed.
- bcd  output  12  {hundreds, tens, ones}, 4 bits each.
- overflow  output  1  committed value > 99 (0x63).
- hex_lo  output  7  segments for committed bin[3:0].
- hex_hi  output  7  segments for committed bin[7:4].
- dec_lo  output  7  segments for ones digit, or the overflow glyph.
- dec_hi  output  7  segments for tens digit, or the overflow glyph.

## Operation
- Segment bit order is {g,f,e,d,c,b,a}. All segment outputs are active-low (0 = lit).
- Digit decoder is combinational. Lit-segment patterns before inversion: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
- Display-zero value = 7'b1000000. Overflow glyph = 7'b0011100 (a, b, f, g lit).
- Idle + start=1: latch bin into a shift register, clear the 12-bit BCD scratch, clear the iteration counter, set busy.
- Each busy cycle performs one iteration:
  - For every BCD nibble >= 5, add 3 to that nibble.
  - Shift {scratch, shift register} left by one bit.
- After 8 iterations, a commit cycle writes:
  - bcd = scratch.
  - overflow = (latched bin > 8'h63).
  - hex_lo / hex_hi = decoded latched nibbles.
  - dec_lo / dec_hi = overflow glyph if overflow, else the decoded ones / tens digit.
  - done = 1 for one cycle; busy is cleared.
- Outputs hold their committed values until the next commit or reset.
- The hundreds digit is reported on bcd only; it is never displayed.
- State machine: IDLE -> SHIFT (8 cycles, counter 0..7) -> COMMIT -> IDLE.

## Timing
- Reset (asynchronous, immediate while rst_n=0):
  - busy=0, done=0, overflow=0, bcd=12'h000.
  - All four segment outputs = display-zero (7'b1000000).
  - FSM returns to IDLE.
- start accepted at edge N; iterations occur at edges N+1..N+8; commit occurs at edge N+9.
- done is high from edge N+9 to N+10. busy is high from edge N to edge N+9.
- Latency: 9 cycles from accept to visible result. Throughput: one conversion per 10 cycles.
- start while busy (including the commit edge): ignored, with no effect on the in-flight conversion.
- start on the cycle after done: accepted.
- bin changes after acceptance do not affect the in-flight result.
- Reset mid-conversion: the conversion is aborted, all outputs return to reset values, and no done pulse is produced.

## Test plan
- Reset: assert rst_n=0 asynchronously -> all segment outputs 7'b1000000, bcd=000, overflow=0, busy=0, done=0.
- bin=0x2A with start -> done after 9 cycles; bcd=042; hex_hi=decoded 2 (7'b0100100); hex_lo=decoded A (7'b0001000); dec_hi=decoded 4 (7'b0011001); dec_lo=decoded 2; overflow=0.
- Boundary case: bin=0x63 (99) -> bcd=099, dec digits show 9/9, overflow=0. Then bin=0x64 (100) -> bcd=100, overflow=1, dec_hi=dec_lo=7'b0011100, hex digits show 6/4.
- bin=0xFF -> bcd=255, overflow=1, hex digits F/F (7'b0001110). Sweep all 256 inputs against a reference division model for bcd and overflow.
- Pulse start again at cycles 3 and 9 of a conversion, changing bin at the same time -> result matches the originally latched value, with exactly one done pulse.
- Drop rst_n at iteration 4 -> immediate reset values with no done pulse; a subsequent start converts correctly.
